// File: rtl/pipelined_datapath.sv
// Two-stage execute/writeback datapath: register file, forwarding ALU stage (EX)
// and a writeback stage (WB) that stalls while a load waits for memory.
module pipelined_datapath #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            RegWrite,
    input  logic [3:0]      ALUControl,
    input  logic            ALUSrc,
    input  logic [XLEN-1:0] Imm,
    input  logic [RAW-1:0]  rs1,
    input  logic [RAW-1:0]  rs2,
    input  logic [RAW-1:0]  rd,
    input  logic [XLEN-1:0] PC,
    input  logic [1:0]      MemToReg,
    input  logic [XLEN-1:0] ReadDataMem,
    input  logic            mem_valid,
    output logic [XLEN-1:0] ALUResult,
    output logic [XLEN-1:0] StoreData,
    output logic            Zero,
    output logic [XLEN-1:0] WriteBackData,
    output logic            wb_valid,
    output logic [RAW-1:0]  wb_rd
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    logic [XLEN-1:0] rf_q [NREG];

    logic            wb_valid_q,    wb_valid_d;
    logic            wb_regwrite_q, wb_regwrite_d;
    logic [RAW-1:0]  wb_rd_q,       wb_rd_d;
    logic [1:0]      wb_memtoreg_q, wb_memtoreg_d;
    logic [XLEN-1:0] wb_alu_q,      wb_alu_d;
    logic [XLEN-1:0] wb_pc4_q,      wb_pc4_d;
    logic [XLEN-1:0] wb_imm_q,      wb_imm_d;

    logic            stall;
    logic            wb_fwd;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] alu_y;
    logic [SHW-1:0]  shamt;

    assign stall    = wb_valid_q && (wb_memtoreg_q == WB_MEM) && !mem_valid;
    assign in_ready = !stall;
    assign wb_fwd   = wb_valid_q && wb_regwrite_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;

    always_comb begin
        WriteBackData = wb_alu_q;
        case (wb_memtoreg_q)
            WB_ALU:  WriteBackData = wb_alu_q;
            WB_MEM:  WriteBackData = ReadDataMem;
            WB_PC4:  WriteBackData = wb_pc4_q;
            WB_IMM:  WriteBackData = wb_imm_q;
            default: WriteBackData = wb_alu_q;
        endcase
    end

    // Index 0 override is applied last so forwarding can never leak a value into x0.
    always_comb begin
        op_a = rf_q[rs1];
        if (wb_fwd && (wb_rd_q == rs1)) begin
            op_a = WriteBackData;
        end
        if (rs1 == '0) begin
            op_a = '0;
        end
        rs2_val = rf_q[rs2];
        if (wb_fwd && (wb_rd_q == rs2)) begin
            rs2_val = WriteBackData;
        end
        if (rs2 == '0) begin
            rs2_val = '0;
        end
    end

    assign op_b      = ALUSrc ? Imm : rs2_val;
    assign StoreData = rs2_val;
    assign shamt     = op_b[SHW-1:0];

    always_comb begin
        alu_y = '0;
        case (ALUControl)
            OP_ADD:  alu_y = op_a + op_b;
            OP_SUB:  alu_y = op_a - op_b;
            OP_AND:  alu_y = op_a & op_b;
            OP_OR:   alu_y = op_a | op_b;
            OP_XOR:  alu_y = op_a ^ op_b;
            OP_SLL:  alu_y = op_a << shamt;
            OP_SRL:  alu_y = op_a >> shamt;
            OP_SRA:  alu_y = $signed(op_a) >>> shamt;
            OP_SLT:  alu_y = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_y = XLEN'(op_a < op_b);
            default: alu_y = '0;
        endcase
    end

    assign ALUResult = alu_y;
    assign Zero      = (alu_y == '0);

    always_comb begin
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_rd_d       = wb_rd_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_alu_d      = wb_alu_q;
        wb_pc4_d      = wb_pc4_q;
        wb_imm_d      = wb_imm_q;
        if (!stall) begin
            wb_valid_d    = in_valid;
            wb_regwrite_d = in_valid && RegWrite;
            wb_rd_d       = rd;
            wb_memtoreg_d = MemToReg;
            wb_alu_d      = alu_y;
            wb_pc4_d      = PC + XLEN'(4);
            wb_imm_d      = Imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_memtoreg_q <= WB_ALU;
            wb_alu_q      <= '0;
            wb_pc4_q      <= '0;
            wb_imm_q      <= '0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_alu_q      <= wb_alu_d;
            wb_pc4_q      <= wb_pc4_d;
            wb_imm_q      <= wb_imm_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (!stall && wb_fwd && (wb_rd_q != '0)) begin
            rf_q[wb_rd_q] <= WriteBackData;
        end
    end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Bench for pipelined_datapath: ALU vector table, directed pipeline sequences,
// and random instruction streams against an architectural reference model.
module tb_pipelined_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        RegWrite;
    logic [3:0]  ALUControl;
    logic        ALUSrc;
    logic [31:0] Imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] PC;
    logic [1:0]  MemToReg;
    logic [31:0] ReadDataMem;
    logic        mem_valid;
    logic [31:0] ALUResult;
    logic [31:0] StoreData;
    logic        Zero;
    logic [31:0] WriteBackData;
    logic        wb_valid;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    pipelined_datapath #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .ALUSrc(ALUSrc), .Imm(Imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .PC(PC), .MemToReg(MemToReg),
        .ReadDataMem(ReadDataMem), .mem_valid(mem_valid), .ALUResult(ALUResult),
        .StoreData(StoreData), .Zero(Zero), .WriteBackData(WriteBackData),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        zero;
    } vec_t;

    vec_t vecs[14];

    // Architectural reference: committed registers plus the one instruction in WB.
    logic [31:0] m_rf [32];
    logic        p_valid, p_rw;
    logic [4:0]  p_rd;
    logic [1:0]  p_m2r;
    logic [31:0] p_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; RegWrite = 0; ALUControl = 4'd0; ALUSrc = 0; Imm = '0;
        rs1 = '0; rs2 = '0; rd = '0; PC = '0; MemToReg = 2'b00;
    endtask

    task automatic issue(input logic rw, input logic [3:0] op, input logic src,
                         input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rdv, input logic [31:0] pc, input logic [1:0] m2r);
        in_valid = 1; RegWrite = rw; ALUControl = op; ALUSrc = src; Imm = imm;
        rs1 = r1; rs2 = r2; rd = rdv; PC = pc; MemToReg = m2r;
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        issue(0, 4'd0, 0, '0, r, 5'd0, 5'd0, '0, 2'b00);
        #1;
        v = ALUResult;
        tick();
        idle();
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic [31:0] wbv);
        if (idx == 0) return 32'd0;
        if (p_valid && p_rw && p_rd == idx) return wbv;
        return m_rf[idx];
    endfunction

    initial begin
        logic [31:0] v;
        logic [31:0] wbv, a, b, s2;
        logic        exp_stall;

        vecs[0]  = '{4'd0, 32'd5,         32'd7,         32'd12,        1'b0};
        vecs[1]  = '{4'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
        vecs[3]  = '{4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0};
        vecs[4]  = '{4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0};
        vecs[5]  = '{4'd5, 32'd1,         32'd31,        32'h8000_0000, 1'b0};
        vecs[6]  = '{4'd6, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0};
        vecs[7]  = '{4'd7, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
        vecs[8]  = '{4'd8, 32'h8000_0000, 32'd1,         32'd1,         1'b0};
        vecs[9]  = '{4'd9, 32'h8000_0000, 32'd1,         32'd0,         1'b1};
        vecs[10] = '{4'd6, 32'h8000_0000, 32'd33,        32'h4000_0000, 1'b0};
        vecs[11] = '{4'd7, 32'h8000_0000, 32'd33,        32'hC000_0000, 1'b0};
        vecs[12] = '{4'd15, 32'hFFFF_FFFF, 32'd3,        32'd0,         1'b1};
        vecs[13] = '{4'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};

        idle();
        rst = 1; mem_valid = 1; ReadDataMem = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset while a load is stalled in WB.
        issue(1, 4'd0, 1, 32'h100, 5'd0, 5'd0, 5'd3, '0, 2'b01);
        mem_valid = 0;
        tick();
        idle();
        check("stall_before_reset", {31'd0, in_ready}, 32'd0);
        tick();
        #1 rst = 1;
        #1;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wbdata", WriteBackData, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #3 rst = 0;
        mem_valid = 1;
        for (int r = 0; r < 32; r++) begin
            read_reg(5'(r), v);
            check($sformatf("rst_reg_x%0d", r), v, 32'd0);
        end

        // ALU table: x5 loaded via LUI-style write, consumed next cycle through forwarding.
        for (int i = 0; i < 14; i++) begin
            issue(1, 4'd0, 0, vecs[i].a, 5'd0, 5'd0, 5'd5, '0, 2'b11);
            tick();
            issue(0, vecs[i].op, 1, vecs[i].b, 5'd5, 5'd0, 5'd0, '0, 2'b00);
            #1;
            check($sformatf("vec%0d_alu", i), ALUResult, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), {31'd0, Zero}, {31'd0, vecs[i].zero});
            tick();
            idle();
        end

        // ADDI x1,x0,5 then ADD x2,x1,x1 via forwarding.
        issue(1, 4'd0, 1, 32'd5, 5'd0, 5'd0, 5'd1, '0, 2'b00);
        tick();
        issue(1, 4'd0, 0, '0, 5'd1, 5'd1, 5'd2, '0, 2'b00);
        #1 check("fwd_add", ALUResult, 32'd10);
        tick();
        idle();
        tick();
        read_reg(5'd2, v); check("x2_written", v, 32'd10);
        read_reg(5'd1, v); check("x1_written", v, 32'd5);

        // Load to x3 waiting three cycles, dependent SUB x4,x3,x0 held in EX.
        mem_valid = 0;
        issue(1, 4'd0, 1, 32'h100, 5'd0, 5'd0, 5'd3, '0, 2'b01);
        tick();
        issue(1, 4'd1, 0, '0, 5'd3, 5'd0, 5'd4, '0, 2'b00);
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("load_stall_c%0d", c), {31'd0, in_ready}, 32'd0);
            tick();
        end
        mem_valid = 1; ReadDataMem = 32'hDEAD_BEEF;
        #1;
        check("load_release_ready", {31'd0, in_ready}, 32'd1);
        check("load_wbdata", WriteBackData, 32'hDEAD_BEEF);
        check("dep_sub_alu", ALUResult, 32'hDEAD_BEEF);
        tick();
        idle();
        ReadDataMem = 32'h0;
        #1 check("sub_wbdata", WriteBackData, 32'hDEAD_BEEF);
        tick();
        read_reg(5'd3, v); check("x3_load", v, 32'hDEAD_BEEF);
        read_reg(5'd4, v); check("x4_sub", v, 32'hDEAD_BEEF);

        // JAL-style PC+4 wraps; LUI-style immediate.
        issue(1, 4'd0, 0, '0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFC, 2'b10);
        tick();
        idle();
        #1 check("jal_wbdata", WriteBackData, 32'd0);
        tick();
        read_reg(5'd1, v); check("x1_jal", v, 32'd0);
        issue(1, 4'd0, 0, 32'h1234_5000, 5'd0, 5'd0, 5'd7, '0, 2'b11);
        tick();
        idle();
        #1 check("lui_wbdata", WriteBackData, 32'h1234_5000);
        tick();

        // ADDI x0,x0,7: neither the write nor forwarding may affect x0.
        issue(1, 4'd0, 1, 32'd7, 5'd0, 5'd0, 5'd0, '0, 2'b00);
        tick();
        issue(0, 4'd0, 1, 32'd0, 5'd0, 5'd0, 5'd0, '0, 2'b00);
        #1;
        check("x0_fwd_alu", ALUResult, 32'd0);
        check("x0_zero", {31'd0, Zero}, 32'd1);
        tick();
        idle();
        tick();
        read_reg(5'd0, v); check("x0_after", v, 32'd0);

        // Random streams against the reference model, from a fresh reset.
        rst = 1;
        #2 rst = 0;
        for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
        p_valid = 0; p_rw = 0; p_rd = '0; p_m2r = 2'b00; p_data = '0;
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            RegWrite    = $urandom_range(0, 1) == 1;
            ALUControl  = 4'($urandom_range(0, 15));
            ALUSrc      = $urandom_range(0, 1) == 1;
            Imm         = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            rd          = 5'($urandom_range(0, 7));
            PC          = $urandom;
            MemToReg    = 2'($urandom_range(0, 3));
            ReadDataMem = $urandom;
            mem_valid   = ($urandom_range(0, 2) != 0);
            #1;
            exp_stall = p_valid && p_m2r == 2'b01 && !mem_valid;
            wbv = (p_m2r == 2'b01) ? ReadDataMem : p_data;
            check("rnd_in_ready", {31'd0, in_ready}, {31'd0, !exp_stall});
            check("rnd_wb_valid", {31'd0, wb_valid}, {31'd0, p_valid});
            a = '0;
            s2 = '0;
            if (!exp_stall) begin
                if (p_valid) check("rnd_wbdata", WriteBackData, wbv);
                a  = m_read(rs1, wbv);
                s2 = m_read(rs2, wbv);
                b  = ALUSrc ? Imm : s2;
                check("rnd_alu", ALUResult, alu_ref(ALUControl, a, b));
                check("rnd_store", StoreData, s2);
                check("rnd_zero", {31'd0, Zero}, {31'd0, alu_ref(ALUControl, a, b) == 0});
            end
            tick();
            if (!exp_stall) begin
                if (p_valid && p_rw && p_rd != 0) m_rf[p_rd] = wbv;
                p_valid = in_valid;
                p_rw    = in_valid && RegWrite;
                p_rd    = rd;
                p_m2r   = MemToReg;
                case (MemToReg)
                    2'b10:   p_data = PC + 32'd4;
                    2'b11:   p_data = Imm;
                    default: p_data = alu_ref(ALUControl, a, ALUSrc ? Imm : s2);
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised two-stage execute/writeback datapath: the successor to the single-cycle register-file + ALU + writeback-mux datapath.
- Stage EX reads operands from an internal register file, forwards from WB, selects an immediate or register operand, and computes the ALU result.
- The EX/WB pipeline register feeds stage WB, which selects writeback data and writes the register file.
- A valid/ready handshake plus a memory-wait stall let the control unit issue one instruction per cycle.

Parameters:
- XLEN, 32, datapath and register width.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- RAW, $clog2(NREG), register-index width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction fields below are valid this cycle.
- in_ready  out  1  EX can accept this cycle; an instruction is accepted when in_valid && in_ready.
- RegWrite  in  1  instruction writes rd.
- ALUControl  in  4  ALU operation.
- ALUSrc  in  1  ALU B operand: 0 = rs2 value, 1 = Imm.
- Imm  in  XLEN  sign-extended immediate.
- rs1, rs2, rd  in  RAW  register indices.
- PC  in  XLEN  PC of the instruction.
- MemToReg  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 Imm (LUI).
- ReadDataMem  in  XLEN  load data for the instruction in WB.
- mem_valid  in  1  ReadDataMem valid; only examined when the WB instruction is a load.
- ALUResult  out  XLEN  combinational EX-stage ALU result (memory address/store path).
- StoreData  out  XLEN  forwarded rs2 value in EX.
- Zero  out  1  ALUResult == 0 (branch compare).
- WriteBackData  out  XLEN  WB-stage selected data.
- wb_valid  out  1  WB stage holds a valid instruction.
- wb_rd  out  RAW  destination of the WB instruction.

Behaviour:
- Reset (async): every register-file entry = 0; EX/WB register cleared (wb_valid=0, wb_rd=0, stored ALU/PC/Imm=0, MemToReg=00, RegWrite=0). WriteBackData therefore reads 0. A WB instruction pending at reset is dropped and never written.
- ALU ops:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[$clog2(XLEN)-1:0].
  - 1000 SLT (signed), 1001 SLTU; result is 1 or 0, zero-extended.
  - Any other code gives 0. Arithmetic wraps modulo 2^XLEN.
- Operand read:
  - Index 0 always reads 0, regardless of forwarding.
  - Otherwise, forward WriteBackData if wb_valid && wb RegWrite && wb_rd == index.
  - Otherwise read the register-file entry.
  - Forwarding has priority over the register file.
- WB mux: 00 stored ALU result; 01 ReadDataMem; 10 stored PC+4 (computed in EX, wraps); 11 stored Imm.
- Stall: stall = wb_valid && MemToReg_wb == 01 && !mem_valid.
  - in_ready = !stall.
  - While stalled, the EX/WB register holds and there is no register-file write.
  - EX outputs still reflect the current inputs but are not captured.
- Pipeline advance (when !stall, on the edge):
  - The EX/WB register captures the accepted instruction, or a bubble (wb_valid=0) if in_valid=0.
  - The register file writes WriteBackData to wb_rd iff wb_valid && RegWrite_wb && wb_rd != 0.
- Latency: an instruction accepted in cycle N is in WB in cycle N+1 and its register is written at the end of N+1 (later if stalled). A dependent instruction issued in N+1 gets the value by forwarding; one issued in N+2 or later reads the register file.
- Writes to x0 are suppressed. The forward path never supplies a nonzero value for x0.
- Simultaneous write and read of the same register in the same cycle returns the new value via forwarding.

Test Plan:
- Reset mid-load-stall, then release → wb_valid=0, WriteBackData=0, in_ready=1; all registers read 0.
- Issue ADDI x1,x0,5 (ALUSrc=1, Imm=5, ADD), then ADD x2,x1,x1 next cycle → ALUResult=10 via forwarding; x2=10 written two cycles later.
- Load to x3 in WB with mem_valid=0 for 3 cycles, then mem_valid=1 with ReadDataMem=0xDEADBEEF → in_ready=0 for exactly those 3 cycles. Dependent SUB x4,x3,x0 held in EX then computes 0xDEADBEEF. x3 is written once.
- JAL-style (MemToReg=10, PC=0xFFFFFFFC, rd=x1) → x1=0x00000000 (wraps). LUI-style (MemToReg=11, Imm=0x12345000) → WriteBackData=0x12345000.
- ADDI x0,x0,7, then read x0 → ALUResult for x0+0 = 0; Zero=1.
- Shifts and compares with x5=0x80000000:
  - SRA by 4 → 0xF8000000.
  - SRL by 4 → 0x08000000.
  - SLT x5 vs 1 → 1.
  - SLTU x5 vs 1 → 0.
  - Shift amount 33 → behaves as 1.
